// File: rtl/alu_issue_wb_pkg.sv
// alu_issue_wb_pkg: shared widths, ALU op encodings, funct codes and funct decoder.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package alu_issue_wb_pkg;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } decode_t;

    function automatic decode_t decode_funct(input logic [5:0] funct);
        decode_t d;
        d.legal = 1'b1;
        d.op    = OP_ADD;
        case (funct)
            FUNCT_ADD: d.op = OP_ADD;
            FUNCT_SUB: d.op = OP_SUB;
            FUNCT_AND: d.op = OP_AND;
            FUNCT_OR:  d.op = OP_OR;
            FUNCT_SLT: d.op = OP_SLT;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_wb_regfile4x4.sv
// regfile4x4: 4x4 register file, two async read ports, one sync write port, r0 fixed at zero.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module regfile4x4
    import alu_issue_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [REG_AW-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] r_regs [0:NUM_REGS-1];

    // r0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = r_regs[rd_addr0];
    assign rd_data1 = r_regs[rd_addr1];

endmodule

`default_nettype wire

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: decode/issue stage driving a 4-bit ALU and its write-back stage.
// Revision: 1.0. Optional macro ALU_FORWARD_EN: forward alu_result on hazards instead of stalling.
`timescale 1ns/1ps
`default_nettype none

module alu_issue_wb
    import alu_issue_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic              in_ldi,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              zero_flag,
    output logic              err
);

    decode_t           w_dec;
    logic [DATA_W-1:0] w_rs_data, w_rt_data, w_opnd_a, w_opnd_b;
    logic              w_ex_fwd, w_haz_rs, w_haz_rt, w_accept, w_wb_legal;

    logic              r_ex_valid, r_ex_illegal;
    alu_op_e           r_ex_op;
    logic [DATA_W-1:0] r_ex_a, r_ex_b;
    logic [REG_AW-1:0] r_ex_rd;

    logic              r_out_valid, r_zero_flag, r_err;
    logic [DATA_W-1:0] r_out_result;
    logic [REG_AW-1:0] r_out_rd;

    assign w_dec      = decode_funct(in_funct);
    assign w_wb_legal = r_ex_valid & ~r_ex_illegal;

    // Only a legal in-flight write to a real register can make the regfile read stale.
    assign w_ex_fwd = w_wb_legal & (r_ex_rd != '0);
    assign w_haz_rs = in_valid & ~in_ldi & w_ex_fwd & (in_rs == r_ex_rd);
    assign w_haz_rt = in_valid & ~in_ldi & w_ex_fwd & (in_rt == r_ex_rd);

`ifdef ALU_FORWARD_EN
    assign in_ready = 1'b1;
    assign w_opnd_a = w_haz_rs ? alu_result : w_rs_data;
    assign w_opnd_b = w_haz_rt ? alu_result : w_rt_data;
`else
    assign in_ready = ~(w_haz_rs | w_haz_rt);
    assign w_opnd_a = w_rs_data;
    assign w_opnd_b = w_rt_data;
`endif

    assign w_accept = in_valid & in_ready;

    regfile4x4 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (in_rs),
        .rd_data0 (w_rs_data),
        .rd_addr1 (in_rt),
        .rd_data1 (w_rt_data),
        .wr_en    (w_wb_legal),
        .wr_addr  (r_ex_rd),
        .wr_data  (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_illegal <= 1'b0;
            r_ex_op      <= OP_AND;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_rd      <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_op      <= in_ldi ? OP_ADD : w_dec.op;
                r_ex_a       <= in_ldi ? '0 : w_opnd_a;
                r_ex_b       <= in_ldi ? in_imm : w_opnd_b;
                r_ex_rd      <= in_rd;
                r_ex_illegal <= ~in_ldi & ~w_dec.legal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_zero_flag  <= 1'b0;
        end else begin
            r_out_valid <= w_wb_legal;
            r_err       <= r_ex_valid & r_ex_illegal;
            if (w_wb_legal) begin
                r_out_result <= alu_result;
                r_out_rd     <= r_ex_rd;
                r_zero_flag  <= alu_zero;
            end
        end
    end

    assign alu_a      = r_ex_a;
    assign alu_b      = r_ex_b;
    assign alu_op     = r_ex_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_rd     = r_out_rd;
    assign zero_flag  = r_zero_flag;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed self-checking bench for alu_issue_wb with a behavioural 4-bit ALU.
// Revision: 1.0. Honours ALU_FORWARD_EN for the expected stall count.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue_wb;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_ldi;
    logic [5:0] in_funct;
    logic [3:0] in_imm;
    logic [1:0] in_rs, in_rt, in_rd;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       out_valid, zero_flag, err;
    logic [3:0] out_result;
    logic [1:0] out_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int both_cnt = 0;
    int stalls;

    logic [3:0] wb_res [$];
    logic [1:0] wb_rd  [$];

`ifdef ALU_FORWARD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    always #5 clk = ~clk;

    alu_issue_wb dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct   (in_funct),
        .in_ldi     (in_ldi),
        .in_imm     (in_imm),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_rd     (out_rd),
        .zero_flag  (zero_flag),
        .err        (err)
    );

    // Reference ALU
    always_comb begin
        alu_result = 4'h0;
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 4'h1 : 4'h0;
            default: alu_result = 4'h0;
        endcase
        alu_zero = (alu_result == 4'h0);
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            wb_res.push_back(out_result);
            wb_rd.push_back(out_rd);
        end
        if (out_valid === 1'b1 && err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ldi, input logic [5:0] funct, input logic [3:0] imm,
                        input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                        output int nstall);
        logic acc;
        acc = 1'b0;
        nstall = 0;
        in_valid = 1'b1; in_ldi = ldi; in_funct = funct; in_imm = imm;
        in_rs = rs; in_rt = rt; in_rd = rd;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) nstall++;
            @(posedge clk);
            #1;
        end
        check("accepted", {7'd0, acc}, 8'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input string tag, input logic [3:0] res, input logic [1:0] rd);
        logic [3:0] r;
        logic [1:0] d;
        r = 'x;
        d = 'x;
        if (wb_res.size() > 0) begin
            r = wb_res.pop_front();
            d = wb_rd.pop_front();
        end
        check({tag, "_res"}, {4'd0, r}, {4'd0, res});
        check({tag, "_rd"}, {6'd0, d}, {6'd0, rd});
    endtask

    // Reads a register by issuing "or r0, idx, r0"; r0 discards the write but out_result shows it.
    task automatic read_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        int st;
        wb_res.delete();
        wb_rd.delete();
        send(1'b0, 6'h25, 4'h0, idx, 2'd0, 2'd0, st);
        drain();
        expect_wb(tag, exp, 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_ldi = 1'b0; in_funct = 6'h0; in_imm = 4'h0;
        in_rs = 2'd0; in_rt = 2'd0; in_rd = 2'd0;
        #2;
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_out_result", {4'd0, out_result}, 8'd0);
        check("rst_out_rd", {6'd0, out_rd}, 8'd0);
        check("rst_zero_flag", {7'd0, zero_flag}, 8'd0);
        check("rst_err", {7'd0, err}, 8'd0);
        check("rst_alu_a", {4'd0, alu_a}, 8'd0);
        check("rst_alu_b", {4'd0, alu_b}, 8'd0);
        check("rst_alu_op", {5'd0, alu_op}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ldi r1,5; ldi r2,3; add r3,r1,r2
        send(1'b1, 6'h00, 4'd5, 2'd0, 2'd0, 2'd1, stalls);
        check("ldi_alu_a", {4'd0, alu_a}, 8'd0);
        check("ldi_alu_b", {4'd0, alu_b}, 8'd5);
        check("ldi_alu_op", {5'd0, alu_op}, 8'b010);
        check("ldi_no_wb_yet", {7'd0, out_valid}, 8'd0);
        send(1'b1, 6'h00, 4'd3, 2'd0, 2'd0, 2'd2, stalls);
        check("ldi_wb_valid", {7'd0, out_valid}, 8'd1);
        check("ldi_wb_result", {4'd0, out_result}, 8'd5);
        send(1'b0, 6'h20, 4'd0, 2'd1, 2'd2, 2'd3, stalls);
        check("add_stalls", stalls[7:0], EXP_STALL[7:0]);
        drain();
        expect_wb("wb_ldi_r1", 4'd5, 2'd1);
        expect_wb("wb_ldi_r2", 4'd3, 2'd2);
        expect_wb("wb_add_r3", 4'd8, 2'd3);
        check("add_zero_flag", {7'd0, zero_flag}, 8'd0);

        // sub r3,r1,r1 -> 0 ; slt r1,r2,r1 -> 1
        send(1'b0, 6'h22, 4'd0, 2'd1, 2'd1, 2'd3, stalls);
        drain();
        expect_wb("wb_sub", 4'd0, 2'd3);
        check("sub_zero_flag", {7'd0, zero_flag}, 8'd1);
        send(1'b0, 6'h2A, 4'd0, 2'd2, 2'd1, 2'd1, stalls);
        drain();
        expect_wb("wb_slt", 4'd1, 2'd1);
        check("slt_zero_flag", {7'd0, zero_flag}, 8'd0);

        // Hazard: ldi r1,7 ; and r2,r1,r1
        send(1'b1, 6'h00, 4'd7, 2'd0, 2'd0, 2'd1, stalls);
        send(1'b0, 6'h24, 4'd0, 2'd1, 2'd1, 2'd2, stalls);
        check("haz_stalls", stalls[7:0], EXP_STALL[7:0]);
        drain();
        expect_wb("wb_haz_ldi", 4'd7, 2'd1);
        expect_wb("wb_haz_and", 4'd7, 2'd2);
        read_reg("rd_r2_haz", 2'd2, 4'd7);

        // Illegal funct: err pulse, no register or zero_flag update
        send(1'b0, 6'h22, 4'd0, 2'd1, 2'd1, 2'd3, stalls);
        drain();
        check("pre_ill_zero", {7'd0, zero_flag}, 8'd1);
        wb_res.delete();
        wb_rd.delete();
        send(1'b0, 6'h3F, 4'd0, 2'd0, 2'd0, 2'd2, stalls);
        in_valid = 1'b0;
        check("ill_err_early", {7'd0, err}, 8'd0);
        @(posedge clk); #1;
        check("ill_err_pulse", {7'd0, err}, 8'd1);
        check("ill_out_valid", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        check("ill_err_clear", {7'd0, err}, 8'd0);
        check("ill_zero_kept", {7'd0, zero_flag}, 8'd1);
        check("ill_no_wb", wb_res.size(), 8'd0);
        read_reg("rd_r2_ill", 2'd2, 4'd7);

        // Write to r0
        wb_res.delete();
        wb_rd.delete();
        send(1'b1, 6'h00, 4'd9, 2'd0, 2'd0, 2'd0, stalls);
        drain();
        expect_wb("wb_ldi_r0", 4'd9, 2'd0);
        read_reg("rd_r0", 2'd0, 4'd0);

        // Reset while add r3 is in EX
        wb_res.delete();
        wb_rd.delete();
        send(1'b0, 6'h20, 4'd0, 2'd1, 2'd2, 2'd3, stalls);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_alu_a", {4'd0, alu_a}, 8'd0);
        check("mid_rst_alu_op", {5'd0, alu_op}, 8'd0);
        check("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("mid_rst_out_result", {4'd0, out_result}, 8'd0);
        check("mid_rst_zero", {7'd0, zero_flag}, 8'd0);
        check("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        drain();
        check("mid_rst_no_wb", wb_res.size(), 8'd0);
        read_reg("rd_r3_rst", 2'd3, 4'd0);
        read_reg("rd_r1_rst", 2'd1, 4'd0);

        check("never_both", both_cnt[7:0], 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
